// File: rtl/vscale_retire_trace_buf_pkg.sv
// Shared definitions for the retirement-trace buffer.
//   trace_rec_t : one packed trace record, with cycle in the MSBs and ecode in the LSBs
//   REC_WIDTH   : width of trace_rec_t, used as the FIFO data width
//   TRACE_DEPTH : default FIFO depth
//   ECODE_WIDTH : exception cause width, matching the vscale control constants
package vscale_retire_trace_buf_pkg;

    localparam int unsigned ECODE_WIDTH = 4;
    localparam int unsigned TRACE_DEPTH = 16;

    typedef struct packed {
        logic [31:0]            cycle;
        logic [31:0]            pc;
        logic [31:0]            inst;
        logic [4:0]             rd;
        logic [31:0]            wdata;
        logic                   exc;
        logic [ECODE_WIDTH-1:0] ecode;
    } trace_rec_t;

    localparam int unsigned REC_WIDTH = $bits(trace_rec_t);

endpackage

// File: rtl/vscale_sync_fifo.sv
// Synchronous FIFO built from a register array.
//   clk, reset   : clock and synchronous active-high reset
//   push, wdata  : write request and data; a push while full is accepted only together with a pop
//   full         : occupancy == DEPTH
//   pop          : read request; ignored while empty
//   valid, rdata : head-entry qualifier and head data, which is zero while empty
//   count        : occupancy, 0..DEPTH
module vscale_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    output logic                     full,
    input  logic                     pop,
    output logic                     valid,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullCount = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign valid   = (count_q != '0);
    assign full    = (count_q == FullCount);
    assign do_pop  = pop & valid;
    // A full FIFO can still take a push when the head leaves on the same edge.
    assign do_push = push & (~full | do_pop);
    assign rdata   = valid ? mem_q[rd_ptr_q] : '0;
    assign count   = count_q;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Data storage is not reset; rdata is gated by valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/vscale_retire_trace_buf.sv
// Retirement-trace capture behind the vscale WB stage.
//   clk, reset         : core clock and synchronous active-high reset
//   enable             : when 1, retire and exception events are captured
//   PC_DX, inst_DX     : DX-stage PC and instruction, shadowed into WB unless stall_DX is set
//   retire_WB, wr_reg_WB, reg_to_wr_WB, wb_data_WB : WB retirement information
//   exception_WB, exception_code_WB                : WB exception information
//   cycle              : free-running cycle count; bits [31:0] are recorded
//   rec_*              : head record with valid/ready handshake; data is zero while empty
//   count              : records held
//   drop_count         : saturating count of records lost to a full buffer
//   overflow           : sticky flag, set on the first drop
module vscale_retire_trace_buf
    import vscale_retire_trace_buf_pkg::*;
#(
    parameter int unsigned DEPTH  = TRACE_DEPTH,
    parameter int unsigned DROP_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [31:0]            PC_DX,
    input  logic [31:0]            inst_DX,
    input  logic                   stall_DX,
    input  logic                   retire_WB,
    input  logic                   wr_reg_WB,
    input  logic [4:0]             reg_to_wr_WB,
    input  logic [31:0]            wb_data_WB,
    input  logic                   exception_WB,
    input  logic [ECODE_WIDTH-1:0] exception_code_WB,
    input  logic [63:0]            cycle,
    output logic                   rec_valid,
    input  logic                   rec_ready,
    output logic [31:0]            rec_cycle,
    output logic [31:0]            rec_pc,
    output logic [31:0]            rec_inst,
    output logic [4:0]             rec_rd,
    output logic [31:0]            rec_wdata,
    output logic                   rec_exc,
    output logic [ECODE_WIDTH-1:0] rec_ecode,
    output logic [$clog2(DEPTH):0] count,
    output logic [DROP_W-1:0]      drop_count,
    output logic                   overflow
);

    logic [31:0]          pc_wb_q, inst_wb_q;
    logic [DROP_W-1:0]    drop_count_q;
    logic                 overflow_q;
    logic                 ev, fifo_full, drop;
    logic [4:0]           rd;
    trace_rec_t           rec_in, rec_out;
    logic [REC_WIDTH-1:0] rec_out_bits;
    logic                 unused_cycle_hi;

    assign unused_cycle_hi = ^cycle[63:32];

    assign ev = enable & (retire_WB | exception_WB);
    assign rd = (wr_reg_WB && reg_to_wr_WB != 5'd0) ? reg_to_wr_WB : 5'd0;

    always_comb begin
        rec_in.cycle = cycle[31:0];
        rec_in.pc    = pc_wb_q;
        rec_in.inst  = inst_wb_q;
        rec_in.rd    = rd;
        rec_in.wdata = (rd != 5'd0) ? wb_data_WB : 32'd0;
        rec_in.exc   = exception_WB;
        rec_in.ecode = exception_WB ? exception_code_WB : '0;
    end

    // The push is lost only when full and the head is not leaving on the same edge.
    assign drop = ev & fifo_full & ~(rec_valid & rec_ready);

    vscale_sync_fifo #(
        .WIDTH (REC_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (ev),
        .wdata (rec_in),
        .full  (fifo_full),
        .pop   (rec_ready),
        .valid (rec_valid),
        .rdata (rec_out_bits),
        .count (count)
    );

    assign rec_out   = rec_out_bits;
    assign rec_cycle = rec_out.cycle;
    assign rec_pc    = rec_out.pc;
    assign rec_inst  = rec_out.inst;
    assign rec_rd    = rec_out.rd;
    assign rec_wdata = rec_out.wdata;
    assign rec_exc   = rec_out.exc;
    assign rec_ecode = rec_out.ecode;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_wb_q      <= '0;
            inst_wb_q    <= '0;
            drop_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            if (!stall_DX) begin
                pc_wb_q   <= PC_DX;
                inst_wb_q <= inst_DX;
            end
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_count_q != '1) begin
                    drop_count_q <= drop_count_q + 1'b1;
                end
            end
        end
    end

    assign drop_count = drop_count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_vscale_retire_trace_buf.sv
module tb_vscale_retire_trace_buf;
    import vscale_retire_trace_buf_pkg::*;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned DROP_W = 16;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   enable;
    logic [31:0]            PC_DX, inst_DX;
    logic                   stall_DX;
    logic                   retire_WB, wr_reg_WB;
    logic [4:0]             reg_to_wr_WB;
    logic [31:0]            wb_data_WB;
    logic                   exception_WB;
    logic [ECODE_WIDTH-1:0] exception_code_WB;
    logic [63:0]            cycle;
    logic                   rec_valid, rec_ready;
    logic [31:0]            rec_cycle, rec_pc, rec_inst, rec_wdata;
    logic [4:0]             rec_rd;
    logic                   rec_exc;
    logic [ECODE_WIDTH-1:0] rec_ecode;
    logic [$clog2(DEPTH):0] count;
    logic [DROP_W-1:0]      drop_count;
    logic                   overflow;

    vscale_retire_trace_buf #(
        .DEPTH  (DEPTH),
        .DROP_W (DROP_W)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .PC_DX             (PC_DX),
        .inst_DX           (inst_DX),
        .stall_DX          (stall_DX),
        .retire_WB         (retire_WB),
        .wr_reg_WB         (wr_reg_WB),
        .reg_to_wr_WB      (reg_to_wr_WB),
        .wb_data_WB        (wb_data_WB),
        .exception_WB      (exception_WB),
        .exception_code_WB (exception_code_WB),
        .cycle             (cycle),
        .rec_valid         (rec_valid),
        .rec_ready         (rec_ready),
        .rec_cycle         (rec_cycle),
        .rec_pc            (rec_pc),
        .rec_inst          (rec_inst),
        .rec_rd            (rec_rd),
        .rec_wdata         (rec_wdata),
        .rec_exc           (rec_exc),
        .rec_ecode         (rec_ecode),
        .count             (count),
        .drop_count        (drop_count),
        .overflow          (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: queue of expected records plus the WB shadow and drop statistics.
    trace_rec_t  mq[$];
    logic [31:0] m_pc, m_inst;
    int          m_drops;
    bit          m_ovf;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        trace_rec_t head, got;
        head = (mq.size() > 0) ? mq[0] : '0;
        got  = {rec_cycle, rec_pc, rec_inst, rec_rd, rec_wdata, rec_exc, rec_ecode};
        check({tag, ".valid"}, 256'(rec_valid), 256'(mq.size() > 0));
        check({tag, ".count"}, 256'(count), 256'(mq.size()));
        check({tag, ".drops"}, 256'(drop_count), 256'(m_drops));
        check({tag, ".ovf"},   256'(overflow), 256'(m_ovf));
        check({tag, ".rec"},   256'(got), 256'(head));
    endtask

    // One clock: the model applies the same edge the DUT sees, then outputs are compared.
    task automatic step(input string tag);
        trace_rec_t r;
        bit ev, pop, was_full;
        ev       = enable && (retire_WB || exception_WB);
        r.cycle  = cycle[31:0];
        r.pc     = m_pc;
        r.inst   = m_inst;
        r.rd     = (wr_reg_WB && reg_to_wr_WB != 0) ? reg_to_wr_WB : 5'd0;
        r.wdata  = (r.rd != 0) ? wb_data_WB : 32'd0;
        r.exc    = exception_WB;
        r.ecode  = exception_WB ? exception_code_WB : '0;
        @(posedge clk);
        if (reset) begin
            mq.delete();
            m_pc = 0; m_inst = 0; m_drops = 0; m_ovf = 0;
        end else begin
            was_full = (mq.size() == DEPTH);
            pop      = (mq.size() > 0) && rec_ready;
            if (pop) void'(mq.pop_front());
            if (ev) begin
                if (was_full && !pop) begin
                    m_ovf = 1;
                    if (m_drops < 65535) m_drops++;
                end else begin
                    mq.push_back(r);
                end
            end
            if (!stall_DX) begin
                m_pc   = PC_DX;
                m_inst = inst_DX;
            end
        end
        #1;
        cycle = cycle + 64'd1;
        check_outputs(tag);
    endtask

    task automatic idle();
        reset = 0; enable = 1; stall_DX = 0; retire_WB = 0; wr_reg_WB = 0;
        reg_to_wr_WB = 0; wb_data_WB = 0; exception_WB = 0; exception_code_WB = 0;
        rec_ready = 0;
    endtask

    task automatic retire(input logic [4:0] rd, input logic [31:0] wd);
        retire_WB = 1; wr_reg_WB = 1; reg_to_wr_WB = rd; wb_data_WB = wd;
    endtask

    initial begin
        cycle = 64'h1_0000_0100;
        PC_DX = 0; inst_DX = 0;
        m_pc = 0; m_inst = 0; m_drops = 0; m_ovf = 0;
        idle();
        reset = 1;
        step("rst0");
        step("rst1");
        idle();

        // 1: single retire
        PC_DX = 32'h0000_0200; inst_DX = 32'h0010_0093;
        step("t1_shadow");
        PC_DX = 32'h0000_0204; inst_DX = 32'h0000_0013;
        retire(5'd1, 32'd1);
        step("t1_push");
        check("t1_pc", 256'(rec_pc), 256'(32'h200));
        check("t1_rd", 256'(rec_rd), 256'(5'd1));
        check("t1_wdata", 256'(rec_wdata), 256'(32'd1));
        idle();
        rec_ready = 1;
        step("t1_drain");

        // 2: store retire and write to x0
        idle();
        retire(5'd7, 32'hdead_beef); wr_reg_WB = 0;
        step("t2_store");
        retire(5'd0, 32'h1234_5678);
        step("t2_x0");
        check("t2_rd", 256'(rec_rd), 256'(5'd0));
        idle(); rec_ready = 1;
        step("t2_d0");
        step("t2_d1");

        // 3: retire and exception together
        idle();
        retire(5'd3, 32'h55); exception_WB = 1; exception_code_WB = 4'd2;
        step("t3_exc");
        check("t3_exc_bit", 256'(rec_exc), 256'(1'b1));
        check("t3_ecode", 256'(rec_ecode), 256'(4'd2));
        idle(); rec_ready = 1;
        step("t3_drain");

        // 4: overflow with DEPTH+3 retires, 5: push+pop while full
        idle();
        for (int i = 0; i < DEPTH + 3; i++) begin
            PC_DX = 32'h1000 + 4 * i; inst_DX = $urandom;
            retire(5'(i + 1), $urandom);
            step("t4_fill");
        end
        check("t4_drops", 256'(drop_count), 256'(16'd3));
        check("t4_count", 256'(count), 256'(16));
        retire(5'd9, 32'hcafe_f00d); rec_ready = 1;
        step("t5_pushpop");
        check("t5_count", 256'(count), 256'(16));
        idle(); rec_ready = 1;
        for (int i = 0; i < DEPTH + 1; i++) step("t4_drain");

        // 6: stall holds the shadow
        idle();
        PC_DX = 32'h0000_0abc; inst_DX = 32'h1111_2222;
        step("t6_load");
        stall_DX = 1;
        for (int i = 0; i < 3; i++) begin
            PC_DX = $urandom; inst_DX = $urandom;
            step("t6_stall");
        end
        retire(5'd4, 32'h44);
        step("t6_retire");
        check("t6_pc", 256'(rec_pc), 256'(32'h0000_0abc));
        idle(); rec_ready = 1;
        step("t6_drain");

        // enable low ignores events
        idle(); enable = 0; retire(5'd5, 32'h5);
        step("en_off");

        // reset with 5 entries held
        idle();
        for (int i = 0; i < 5; i++) begin
            retire(5'(i + 10), $urandom);
            step("rst_fill");
        end
        idle(); reset = 1; rec_ready = 1;
        step("rst_mid");
        idle();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            enable            = ($urandom_range(0, 9) != 0);
            PC_DX             = $urandom;
            inst_DX           = $urandom;
            stall_DX          = ($urandom_range(0, 3) == 0);
            retire_WB         = ($urandom_range(0, 2) != 0);
            exception_WB      = ($urandom_range(0, 7) == 0);
            exception_code_WB = ECODE_WIDTH'($urandom);
            wr_reg_WB         = $urandom_range(0, 1);
            reg_to_wr_WB      = 5'($urandom);
            wb_data_WB        = $urandom;
            rec_ready         = (i % 100 < 50) ? ($urandom_range(0, 3) == 0)
                                               : ($urandom_range(0, 3) != 0);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
